ttc_broadcast_receiver_v2: RTL and testbench

Parametrised successor TTC Channel B receiver.
- Decodes Brcst[7:2] commands into fill type, async-pulse-storage enable, trigger-number and timestamp resets.
- Adds deferred fill-type switching, saturating per-class counters, a sticky clearable error and an optional timestamped command log FIFO.
- Sits between the TTC decoder and the trigger logic / status register bank.

---
 rtl/ttc_pkg.sv | 41 ++++
 rtl/ttc_cmd_log_fifo.sv | 79 +++++++
 rtl/ttc_broadcast_receiver_v2.sv | 195 +++++++++++++++++++
 tb/tb_ttc_broadcast_receiver_v2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared TTC Channel B command codes, command classes and decode helper
package ttc_pkg;

    // Broadcast command codes, Brcst[7:2]
    localparam logic [5:0] CMD_TS_RESET    = 6'b001010;
    localparam logic [5:0] CMD_ASYNC_START = 6'b110000;
    localparam logic [5:0] CMD_ASYNC_STOP  = 6'b100000;

    // Fill-type opcodes carried in info[5:1] of a fill command
    localparam logic [4:0] FILL_OP_1 = 5'd1;
    localparam logic [4:0] FILL_OP_2 = 5'd2;
    localparam logic [4:0] FILL_OP_3 = 5'd3;
    localparam logic [4:0] FILL_OP_7 = 5'd7;

    // Fill type loaded on reset and loopback (muon)
    localparam logic [4:0] DEFAULT_FILL = FILL_OP_1;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ASYNC   = 2'd1,
        TS_RST  = 2'd2,
        UNKNOWN = 2'd3
    } cmd_class_e;

    // Fill takes priority: any code with bit 0 set is a fill command.
    // Async start/stop differ only in bit 4, which becomes the enable value.
    function automatic cmd_class_e classify(input logic [5:0] info);
        cmd_class_e cls;
        if (info[0]) begin
            cls = FILL;
        end else if (info[5] && (info[3:0] == 4'b0000)) begin
            cls = ASYNC;
        end else if (info == CMD_TS_RESET) begin
            cls = TS_RST;
        end else begin
            cls = UNKNOWN;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ttc_cmd_log_fifo.sv
// rtl/ttc_cmd_log_fifo.sv - synchronous first-word-fall-through FIFO with sticky overflow
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clr          synchronous clear of pointers and overflow flag
//   wr_en/wr_data  write request; dropped when full unless a pop happens in the same cycle
//   rd_en        pop request; ignored while empty
//   rd_valid     FIFO non-empty, rd_data shows the head entry
//   overflow     sticky: a write was dropped
module ttc_cmd_log_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         ovf_q, ovf_d;
    logic         empty, full, push, pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot the write needs.
    assign push  = wr_en && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_en && !push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = ovf_q;

endmodule

// File: rtl/ttc_broadcast_receiver_v2.sv
// rtl/ttc_broadcast_receiver_v2.sv - TTC Channel B broadcast command receiver with counters and optional command log
//
// Optional command log FIFO: define TTC_CMD_LOG_EN.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   chan_b_info/valid      Brcst[7:2] command and its strobe
//   evt_count_reset        ECR strobe, independent of commands
//   ttc_loopback           synchronous clear of all state to reset values
//   thres_unknown_ttc      unknown-command error threshold
//   err_clear              clears the sticky error flag
//   fill_type/fill_pending active fill type, deferred value waiting for ECR
//   accept_pulse_triggers  async pulse storage enable
//   reset_trig_num/_timestamp  registered one-cycle pulses
//   known/unknown_cmd_count    saturating command counters
//   error_unknown_ttc      sticky unknown-count-over-threshold flag
//   log_rd_en/valid/data/overflow  command log FIFO (tied 0 when log disabled)
module ttc_broadcast_receiver_v2 #(
    parameter int         CNT_W        = 32,
    parameter logic [4:0] DEFAULT_FILL = ttc_pkg::DEFAULT_FILL,
    parameter bit         APPLY_ON_ECR = 1'b0,
    parameter int         TS_W         = 24,
    parameter int         LOG_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        chan_b_info,
    input  logic              chan_b_valid,
    input  logic              evt_count_reset,
    input  logic              ttc_loopback,
    input  logic [CNT_W-1:0]  thres_unknown_ttc,
    input  logic              err_clear,
    output logic [4:0]        fill_type,
    output logic              fill_pending,
    output logic              accept_pulse_triggers,
    output logic              reset_trig_num,
    output logic              reset_trig_timestamp,
    output logic [CNT_W-1:0]  known_cmd_count,
    output logic [CNT_W-1:0]  unknown_cmd_count,
    output logic              error_unknown_ttc,
    input  logic              log_rd_en,
    output logic              log_valid,
    output logic [TS_W+6:0]   log_data,
    output logic              log_overflow
);

    import ttc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

    cmd_class_e cls;
    logic       cmd_fill, cmd_async, cmd_ts, cmd_unknown, cmd_known;
    logic [4:0] new_fill;

    logic [4:0]       fill_q, fill_d;
    logic [4:0]       pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             apt_q, apt_d;
    logic             rtn_q, rtn_d;
    logic             rts_q, rts_d;
    logic [CNT_W-1:0] known_q, known_d;
    logic [CNT_W-1:0] unk_q, unk_d;
    logic             err_q, err_d;
    logic [TS_W-1:0]  ts_q, ts_d;

    assign cls         = classify(chan_b_info);
    assign cmd_fill    = chan_b_valid && (cls == FILL);
    assign cmd_async   = chan_b_valid && (cls == ASYNC);
    assign cmd_ts      = chan_b_valid && (cls == TS_RST);
    assign cmd_unknown = chan_b_valid && (cls == UNKNOWN);
    assign cmd_known   = cmd_fill || cmd_async || cmd_ts;
    assign new_fill    = chan_b_info[5:1];

    always_comb begin
        fill_d     = fill_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        apt_d      = apt_q;
        rtn_d      = evt_count_reset;
        rts_d      = cmd_ts;
        known_d    = known_q;
        unk_d      = unk_q;
        err_d      = err_q;
        ts_d       = cmd_ts ? '0 : ts_q + TS_ONE;

        if (!APPLY_ON_ECR) begin
            if (cmd_fill) fill_d = new_fill;
        end else begin
            // A fill arriving with the ECR bypasses the pending slot.
            if (cmd_fill && evt_count_reset) begin
                fill_d = new_fill;
                pend_d = 1'b0;
            end else if (cmd_fill) begin
                pend_val_d = new_fill;
                pend_d     = 1'b1;
            end else if (evt_count_reset && pend_q) begin
                fill_d = pend_val_q;
                pend_d = 1'b0;
            end
        end

        if (cmd_async) apt_d = chan_b_info[4];

        if (cmd_known && (known_q != '1)) known_d = known_q + CNT_ONE;
        if (cmd_unknown && (unk_q != '1)) unk_d = unk_q + CNT_ONE;

        // Set has priority over clear while the condition holds.
        if (unk_q > thres_unknown_ttc) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end

        if (ttc_loopback) begin
            fill_d     = DEFAULT_FILL;
            pend_val_d = DEFAULT_FILL;
            pend_d     = 1'b0;
            apt_d      = 1'b0;
            rtn_d      = 1'b0;
            rts_d      = 1'b0;
            known_d    = '0;
            unk_d      = '0;
            err_d      = 1'b0;
            ts_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q     <= DEFAULT_FILL;
            pend_val_q <= DEFAULT_FILL;
            pend_q     <= 1'b0;
            apt_q      <= 1'b0;
            rtn_q      <= 1'b0;
            rts_q      <= 1'b0;
            known_q    <= '0;
            unk_q      <= '0;
            err_q      <= 1'b0;
            ts_q       <= '0;
        end else begin
            fill_q     <= fill_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            apt_q      <= apt_d;
            rtn_q      <= rtn_d;
            rts_q      <= rts_d;
            known_q    <= known_d;
            unk_q      <= unk_d;
            err_q      <= err_d;
            ts_q       <= ts_d;
        end
    end

    assign fill_type             = fill_q;
    assign fill_pending          = pend_q;
    assign accept_pulse_triggers = apt_q;
    assign reset_trig_num        = rtn_q;
    assign reset_trig_timestamp  = rts_q;
    assign known_cmd_count       = known_q;
    assign unknown_cmd_count     = unk_q;
    assign error_unknown_ttc     = err_q;

`ifdef TTC_CMD_LOG_EN
    logic            log_wr;
    logic [TS_W+6:0] log_wdata;

    // Entry uses the timestamp before this cycle's update.
    assign log_wr    = chan_b_valid || evt_count_reset;
    assign log_wdata = {ts_q, evt_count_reset, chan_b_valid ? chan_b_info : 6'b000000};

    ttc_cmd_log_fifo #(
        .W     (TS_W + 7),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .reset    (reset),
        .clr      (ttc_loopback),
        .wr_en    (log_wr),
        .wr_data  (log_wdata),
        .rd_en    (log_rd_en),
        .rd_valid (log_valid),
        .rd_data  (log_data),
        .overflow (log_overflow)
    );
`else
    localparam int unused_log_depth = LOG_DEPTH;
    logic unused_log_rd;
    assign unused_log_rd = log_rd_en;
    assign log_valid     = 1'b0;
    assign log_data      = '0;
    assign log_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_ttc_broadcast_receiver_v2.sv
// tb/tb_ttc_broadcast_receiver_v2.sv - scoreboard bench for ttc_broadcast_receiver_v2
module tb_ttc_broadcast_receiver_v2;

`ifdef TTC_CMD_LOG_EN
    localparam bit LOG_ON = 1'b1;
`else
    localparam bit LOG_ON = 1'b0;
`endif

    localparam int A_FILL = 0, A_APT = 1, A_RTN = 2, A_RTS = 3, A_KNOWN = 4,
                   A_UNK = 5, A_ERR = 6, A_LV = 7, A_LD7 = 8, A_LTS = 9,
                   A_LOVF = 10, B_FILL = 11, B_PEND = 12, B_RTN = 13,
                   B_UNK = 14, B_ERR = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  chan_b_info = '0;
    logic        chan_b_valid = 1'b0;
    logic        evt_count_reset = 1'b0;
    logic        ttc_loopback = 1'b0;
    logic        err_clear = 1'b0;
    logic        log_rd_en = 1'b0;
    logic [31:0] thr_a = 32'd2;
    logic [3:0]  thr_b = 4'd15;

    logic [4:0]  a_fill, b_fill;
    logic        a_pend, b_pend, a_apt, b_apt, a_rtn, b_rtn, a_rts, b_rts;
    logic [31:0] a_known, a_unk;
    logic [3:0]  b_known, b_unk;
    logic        a_err, b_err, a_lv, b_lv, a_lovf, b_lovf;
    logic [30:0] a_ld, b_ld;

    ttc_broadcast_receiver_v2 #(
        .CNT_W(32), .APPLY_ON_ECR(1'b0), .TS_W(24), .LOG_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .chan_b_info(chan_b_info), .chan_b_valid(chan_b_valid),
        .evt_count_reset(evt_count_reset), .ttc_loopback(ttc_loopback),
        .thres_unknown_ttc(thr_a), .err_clear(err_clear),
        .fill_type(a_fill), .fill_pending(a_pend), .accept_pulse_triggers(a_apt),
        .reset_trig_num(a_rtn), .reset_trig_timestamp(a_rts),
        .known_cmd_count(a_known), .unknown_cmd_count(a_unk),
        .error_unknown_ttc(a_err), .log_rd_en(log_rd_en), .log_valid(a_lv),
        .log_data(a_ld), .log_overflow(a_lovf)
    );

    ttc_broadcast_receiver_v2 #(
        .CNT_W(4), .APPLY_ON_ECR(1'b1), .TS_W(24), .LOG_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .chan_b_info(chan_b_info), .chan_b_valid(chan_b_valid),
        .evt_count_reset(evt_count_reset), .ttc_loopback(ttc_loopback),
        .thres_unknown_ttc(thr_b), .err_clear(err_clear),
        .fill_type(b_fill), .fill_pending(b_pend), .accept_pulse_triggers(b_apt),
        .reset_trig_num(b_rtn), .reset_trig_timestamp(b_rts),
        .known_cmd_count(b_known), .unknown_cmd_count(b_unk),
        .error_unknown_ttc(b_err), .log_rd_en(1'b0), .log_valid(b_lv),
        .log_data(b_ld), .log_overflow(b_lovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          id;
        logic [63:0] val;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int total = 0;
    int bad = 0;

    function automatic logic [63:0] actual(input int id);
        logic [63:0] r;
        r = '0;
        case (id)
            A_FILL:  r = {59'd0, a_fill};
            A_APT:   r = {63'd0, a_apt};
            A_RTN:   r = {63'd0, a_rtn};
            A_RTS:   r = {63'd0, a_rts};
            A_KNOWN: r = {32'd0, a_known};
            A_UNK:   r = {32'd0, a_unk};
            A_ERR:   r = {63'd0, a_err};
            A_LV:    r = {63'd0, a_lv};
            A_LD7:   r = {57'd0, a_ld[6:0]};
            A_LTS:   r = {40'd0, a_ld[30:7]};
            A_LOVF:  r = {63'd0, a_lovf};
            B_FILL:  r = {59'd0, b_fill};
            B_PEND:  r = {63'd0, b_pend};
            B_RTN:   r = {63'd0, b_rtn};
            B_UNK:   r = {60'd0, b_unk};
            B_ERR:   r = {63'd0, b_err};
            default: r = '1;
        endcase
        return r;
    endfunction

    // Monitor: outputs settle after the capture edge; compare mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_entry_t e;
            logic [63:0] act;
            e = sb.pop_front();
            act = actual(e.id);
            total++;
            if (e.due != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h (due %0d at %0d)", e.name, act, e.val, e.due, cyc);
            end
        end
    end

    task automatic exp(input int id, input logic [63:0] v, input string nm);
        sb_entry_t e;
        e.due = cyc + 1;
        e.id = id;
        e.val = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic [5:0] info, input logic ecr);
        @(posedge clk);
        #1;
        chan_b_valid = v;
        chan_b_info = info;
        evt_count_reset = ecr;
        err_clear = 1'b0;
        ttc_loopback = 1'b0;
        log_rd_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp(A_FILL, 1, "reset_fill_a");
        exp(A_KNOWN, 0, "reset_known_a");
        exp(A_UNK, 0, "reset_unk_a");
        exp(A_LV, 0, "reset_log_valid");
        exp(B_FILL, 1, "reset_fill_b");
        exp(B_PEND, 0, "reset_pend_b");

        step(1, 6'b000101, 0);
        exp(A_FILL, 2, "fill_immediate");
        exp(A_KNOWN, 1, "known_first");
        exp(B_FILL, 1, "fill_deferred_hold");
        exp(B_PEND, 1, "fill_pending_set");
        step(1, 6'b000111, 0);
        exp(A_FILL, 3, "fill_immediate_2");
        step(1, 6'b001111, 0);
        exp(B_FILL, 1, "fill_deferred_hold_2");
        exp(B_PEND, 1, "fill_pending_overwrite");
        step(0, 6'b000000, 1);
        exp(B_FILL, 7, "fill_applied_on_ecr");
        exp(B_PEND, 0, "fill_pending_cleared");
        exp(B_RTN, 1, "ecr_pulse_b");
        exp(A_RTN, 1, "ecr_pulse_a");
        exp(A_KNOWN, 3, "ecr_not_counted");
        step(0, 6'b000000, 0);
        exp(A_RTN, 0, "ecr_pulse_end");
        step(1, 6'b000011, 1);
        exp(B_FILL, 1, "fill_with_ecr_direct");
        exp(B_PEND, 0, "fill_with_ecr_no_pend");
        exp(A_KNOWN, 4, "known_fill_ecr");

        step(1, 6'b110000, 0);
        exp(A_APT, 1, "async_start");
        step(1, 6'b100000, 0);
        exp(A_APT, 0, "async_stop");
        step(1, 6'b001010, 0);
        exp(A_RTS, 1, "ts_reset_pulse");
        exp(A_KNOWN, 7, "known_after_ts");
        step(0, 6'b000000, 0);
        exp(A_RTS, 0, "ts_reset_pulse_end");

        step(1, 6'b000010, 0);
        step(1, 6'b000010, 0);
        step(1, 6'b000010, 0);
        exp(A_UNK, 3, "unknown_count_3");
        exp(A_ERR, 0, "error_lags_count");
        exp(A_KNOWN, 7, "unknown_not_known");
        step(0, 6'b000000, 0);
        exp(A_ERR, 1, "error_set");
        step(0, 6'b000000, 0);
        err_clear = 1'b1;
        exp(A_ERR, 1, "error_set_wins_clear");
        exp(A_UNK, 3, "counter_kept_on_clear");
        step(0, 6'b000000, 0);
        thr_a = 32'd10;
        exp(A_ERR, 1, "error_sticky");
        step(0, 6'b000000, 0);
        err_clear = 1'b1;
        exp(A_ERR, 0, "error_cleared");
        exp(A_LV, {63'd0, LOG_ON}, "log_has_entries");
        exp(A_LOVF, {63'd0, LOG_ON}, "log_overflow_early");

        for (int i = 1; i <= 17; i++) begin
            step(1, 6'b000010, 0);
            if (i == 12 || i == 13) exp(B_UNK, 15, "unknown_saturate");
        end
        exp(B_UNK, 15, "unknown_saturate_final");
        exp(A_UNK, 20, "unknown_wide_20");
        exp(A_ERR, 1, "error_reset_after_raise");
        exp(B_ERR, 0, "error_sat_not_above_max");

        step(0, 6'b000000, 0);
        ttc_loopback = 1'b1;
        exp(A_UNK, 0, "loopback_unk");
        exp(A_KNOWN, 0, "loopback_known");
        exp(A_ERR, 0, "loopback_err");
        exp(A_LV, 0, "loopback_log_empty");
        exp(A_LOVF, 0, "loopback_ovf");
        exp(B_UNK, 0, "loopback_unk_b");

        step(1, 6'b000101, 0);
        exp(A_LV, {63'd0, LOG_ON}, "log_first_valid");
        exp(A_LD7, LOG_ON ? 64'h05 : 64'h0, "log_first_head");
        step(1, 6'b110000, 0);
        step(1, 6'b000010, 0);
        step(0, 6'b000000, 1);
        exp(A_LOVF, 0, "log_full_no_ovf");
        step(1, 6'b100000, 0);
        log_rd_en = 1'b1;
        exp(A_LD7, LOG_ON ? 64'h30 : 64'h0, "log_pop_write_full");
        exp(A_LOVF, 0, "log_pop_write_no_ovf");
        step(1, 6'b000111, 0);
        exp(A_LOVF, {63'd0, LOG_ON}, "log_drop_ovf");
        exp(A_LD7, LOG_ON ? 64'h30 : 64'h0, "log_drop_head");
        step(0, 6'b000000, 0);
        log_rd_en = 1'b1;
        exp(A_LD7, LOG_ON ? 64'h02 : 64'h0, "log_order_c3");
        step(0, 6'b000000, 0);
        log_rd_en = 1'b1;
        exp(A_LD7, LOG_ON ? 64'h40 : 64'h0, "log_order_ecr");
        step(0, 6'b000000, 0);
        log_rd_en = 1'b1;
        exp(A_LD7, LOG_ON ? 64'h20 : 64'h0, "log_order_c5");
        step(0, 6'b000000, 0);
        log_rd_en = 1'b1;
        exp(A_LV, 0, "log_drained");
        step(0, 6'b000000, 0);
        log_rd_en = 1'b1;
        exp(A_LV, 0, "log_pop_empty_ignored");

        step(1, 6'b001010, 0);
        exp(A_LD7, LOG_ON ? 64'h0A : 64'h0, "log_ts_cmd_entry");
        exp(A_RTS, 1, "ts_reset_pulse_2");
        step(1, 6'b000101, 0);
        step(0, 6'b000000, 0);
        log_rd_en = 1'b1;
        exp(A_LD7, LOG_ON ? 64'h05 : 64'h0, "log_after_ts_data");
        exp(A_LTS, 0, "log_after_ts_stamp");
        step(1, 6'b110000, 0);
        exp(A_APT, 1, "async_start_2");

        step(0, 6'b000000, 0);
        ttc_loopback = 1'b1;
        exp(A_APT, 0, "loopback_apt");
        exp(A_FILL, 1, "loopback_fill");
        exp(B_PEND, 0, "loopback_pend_b");
        exp(A_LV, 0, "loopback_log_empty_2");
        exp(A_LOVF, 0, "loopback_ovf_2");
        exp(A_KNOWN, 0, "loopback_known_2");

        step(0, 6'b000000, 0);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
